// File: rtl/iiitb_sd_prog.sv
// Programmable serial pattern detector with IDLE/ARMED control, overlapping or non-overlapping detection.
// Optional saturating match counter enabled by defining IIITB_SD_CNT_EN.
module iiitb_sd_prog #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             armed,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pattern, pattern_nxt;
  logic [PAT_W-1:0] history, history_nxt, hist_shift;
  logic [FILL_W-1:0] fill, fill_nxt, fill_sat;
  logic             dout_nxt;
  logic             match;

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_FULL) ? f : f + FILL_W'(1);
  endfunction

  // Load has priority over sampling; a match clears fill only in non-overlapping mode.
  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    history_nxt = history;
    fill_nxt    = fill;
    dout_nxt    = 1'b0;
    match       = 1'b0;
    hist_shift  = {history[PAT_W-2:0], din};
    fill_sat    = fill_inc(fill);
    if (pat_load) begin
      state_nxt   = ARMED;
      pattern_nxt = pat_in;
      history_nxt = '0;
      fill_nxt    = '0;
    end else if (state == ARMED && din_valid) begin
      history_nxt = hist_shift;
      match       = (fill_sat == FILL_FULL) && (hist_shift == pattern);
      fill_nxt    = (match && !overlap) ? '0 : fill_sat;
      dout_nxt    = match;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pattern <= '0;
      history <= '0;
      fill    <= '0;
      dout    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pattern <= pattern_nxt;
      history <= history_nxt;
      fill    <= fill_nxt;
      dout    <= dout_nxt;
    end
  end

  assign armed = (state == ARMED);

`ifdef IIITB_SD_CNT_EN
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (pat_load) begin
      cnt <= '0;
    end else if (match) begin
      cnt <= cnt_inc(cnt);
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_iiitb_sd_prog.sv
// Bench for iiitb_sd_prog: directed scenarios plus randomized traffic against a bit-history model.
module tb_iiitb_sd_prog;
  localparam int PW   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          din = 1'b0, din_valid = 1'b0, pat_load = 1'b0, overlap = 1'b0;
  logic [PW-1:0] pat_in = '0;
  logic          armed, dout;
  logic [CW-1:0] match_cnt;

  logic          din_b = 1'b0, dv_b = 1'b0, pl_b = 1'b0, ov_b = 1'b1;
  logic [1:0]    pat_b = 2'b00;
  logic          armed_b, dout_b;
  logic [1:0]    cnt_b;

  iiitb_sd_prog #(.PAT_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .armed(armed), .dout(dout), .match_cnt(match_cnt)
  );

  iiitb_sd_prog #(.PAT_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .din_valid(dv_b), .pat_load(pl_b),
    .pat_in(pat_b), .overlap(ov_b), .armed(armed_b), .dout(dout_b), .match_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: remembers recent sampled bits and how many fresh bits have arrived since the
  // last load or non-overlapping match.
  bit m_armed;
  int m_pat;
  int m_bits[$];
  int m_since;
  int m_cnt;
  bit m_dout;

  function automatic void model_reset();
    m_armed = 0; m_pat = 0; m_bits.delete(); m_since = 0; m_cnt = 0; m_dout = 0;
  endfunction

  function automatic void model_edge(bit l, int p, bit v, bit d, bit ov);
    int val;
    bit hit;
    if (l) begin
      m_armed = 1; m_pat = p; m_bits.delete(); m_since = 0; m_cnt = 0; m_dout = 0;
    end else if (m_armed && v) begin
      m_bits.push_back(int'(d));
      if (m_bits.size() > PW) void'(m_bits.pop_front());
      m_since++;
      hit = 0;
      if (m_since >= PW) begin
        val = 0;
        foreach (m_bits[i]) val = (val << 1) | m_bits[i];
        hit = (val == m_pat);
      end
      m_dout = hit;
      if (hit) begin
        if (m_cnt < CMAX) m_cnt++;
        if (!ov) m_since = 0;
      end
    end else begin
      m_dout = 0;
    end
  endfunction

  function automatic int exp_cnt(input int c);
`ifdef IIITB_SD_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic cycle(input bit l, input logic [PW-1:0] p, input bit v, input bit d, input string tag);
    pat_load = l; pat_in = p; din_valid = v; din = d;
    @(posedge clk);
    model_edge(l, int'(p), v, d, overlap);
    #1;
    check({tag, "_dout"}, dout, m_dout);
    check({tag, "_armed"}, armed, m_armed);
    check({tag, "_cnt"}, match_cnt, exp_cnt(m_cnt));
  endtask

  task automatic load(input logic [PW-1:0] p, input string tag);
    cycle(1'b1, p, 1'b0, 1'b0, tag);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input string tag);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) cycle(1'b0, '0, 1'b1, b[i], tag);
  endtask

  task automatic reset_mid(input string tag);
    @(posedge clk);
    #3;
    din_valid = 1'b1; din = 1'b1; pat_load = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, "_async_dout"}, dout, 0);
    check({tag, "_async_armed"}, armed, 0);
    check({tag, "_async_cnt"}, match_cnt, 0);
    @(posedge clk);
    #1;
    check({tag, "_held_dout"}, dout, 0);
    check({tag, "_held_armed"}, armed, 0);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_armed", armed, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_armed_b", armed_b, 0);
    #2 reset = 1'b1;

    // Idle ignores data until a load.
    cycle(1'b0, '0, 1'b1, 1'b1, "idle");
    cycle(1'b0, '0, 1'b1, 1'b0, "idle");

    overlap = 1'b1;
    load(4'b1001, "s1_load");
    send_bits(16'b1001001, 7, "s1");
    check("s1_total", match_cnt, exp_cnt(2));

    overlap = 1'b0;
    load(4'b1001, "s2_load");
    send_bits(16'b1001001, 7, "s2");
    check("s2_total", match_cnt, exp_cnt(1));

    load(4'b1001, "s3_load");
    send_bits(16'b10, 2, "s3a");
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, "s3gap");
    send_bits(16'b01, 2, "s3b");
    check("s3_pulse", dout, 1);

    send_bits(16'b100, 3, "s4pre");
    cycle(1'b1, 4'b0110, 1'b1, 1'b1, "s4load");
    check("s4_cnt_clear", match_cnt, 0);
    send_bits(16'b0110, 4, "s4");
    check("s4_pulse", dout, 1);

    load(4'b1001, "s5_load");
    send_bits(16'b100, 3, "s5pre");
    reset_mid("s5");
    cycle(1'b0, '0, 1'b1, 1'b1, "s5post");
    check("s5_armed", armed, 0);

    // Randomized traffic with occasional reloads, overlap flips and async resets.
    overlap = 1'b1;
    load(4'($urandom), "rnd_load0");
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 7) == 0) overlap = ~overlap;
      if ($urandom_range(0, 199) == 0) begin
        reset_mid("rnd");
      end else begin
        cycle(($urandom_range(0, 29) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
              1'($urandom), "rnd");
      end
    end

    // Narrow instance: counter saturation with pattern 11 and six consecutive ones.
    pl_b = 1'b1; pat_b = 2'b11; ov_b = 1'b1; dv_b = 1'b0;
    @(posedge clk);
    #1;
    check("b_load_armed", armed_b, 1);
    check("b_load_cnt", cnt_b, 0);
    pl_b = 1'b0; dv_b = 1'b1; din_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check("b_dout", dout_b, (k >= 2) ? 1 : 0);
      check("b_cnt", cnt_b, exp_cnt((k - 1 > 3) ? 3 : k - 1));
    end
    dv_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/iiitb_sd_prog.md
IIITB_SD_PROG -- requirements
Module: iiitb_sd_prog

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the match counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: one clock, reset asynchronous and active-low.
REQ-005 The block SHALL have port din, input, 1, the serial data bit.
REQ-006 The block SHALL have port din_valid, input, 1; when high, din is sampled at this clock edge.
REQ-007 The block SHALL have port pat_load, input, 1; when high, a pattern load occurs at this edge.
REQ-008 The block SHALL have port pat_in, input, PAT_W.
- Carries the pattern to load.
- pat_in[PAT_W-1] is the first bit expected; pat_in[0] is the last.
REQ-009 The block SHALL have port overlap, input, 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-010 The block SHALL have port armed, output, 1; high while the block is in ARMED.
REQ-011 The block SHALL have port dout, output, 1, a registered match pulse.
REQ-012 The block SHALL have port match_cnt, output, CNT_W, the number of matches.

Function
REQ-013 The block SHALL implement an FSM with exactly two states: IDLE and ARMED.
- IDLE to ARMED on pat_load.
- ARMED stays in ARMED on pat_load (reload).
- No other transitions except reset.
REQ-014 In IDLE, din_valid SHALL be ignored and dout SHALL be 0.
REQ-015 On a pat_load edge, the block SHALL perform the load actions:
- pattern register <= pat_in.
- history <= 0 and fill count <= 0.
- dout <= 0 and match_cnt <= 0.
- din is discarded even if din_valid is high; pat_load has priority.
REQ-016 In ARMED with din_valid=1 and pat_load=0, history SHALL update as a PAT_W-bit shift register: {history[PAT_W-2:0], din}.
- Fill count increments, saturating at PAT_W.
REQ-017 A match SHALL be declared at an edge when both hold:
- The updated fill count equals PAT_W.
- The updated history equals the pattern register.
REQ-018 dout SHALL be registered.
- Set to 1 at the same edge the final pattern bit is sampled (visible the following cycle).
- Returns to 0 at the next edge unless another match occurs.
REQ-019 With din_valid=0, history and fill count SHALL hold, and dout SHALL be 0 after that edge.
REQ-020 With overlap=1, history and fill count SHALL be retained after a match, so a pattern suffix can begin the next match.
REQ-021 With overlap=0, the fill count SHALL be cleared to 0 at the match edge, so the next match needs PAT_W fresh bits.
REQ-022 A change of overlap SHALL take effect at the next sampled bit; history SHALL NOT be altered by the change itself.
REQ-023 armed SHALL be a direct decode of the FSM state.

Reset
REQ-024 Assertion of reset (low) SHALL asynchronously force the reset values:
- FSM = IDLE, pattern = 0, history = 0, fill count = 0.
- dout = 0, armed = 0, match_cnt = 0.
REQ-025 Reset asserted mid-stream SHALL discard any partial match, and no dout pulse SHALL occur for bits sampled before release.
REQ-026 After reset deasserts, the block SHALL remain in IDLE until pat_load.

Configuration
REQ-027 With macro IIITB_SD_CNT_EN defined, match_cnt SHALL behave as follows:
- Increments by 1 at every match edge.
- Saturates at 2^CNT_W-1.
- Clears on pat_load and on reset.
REQ-028 Without IIITB_SD_CNT_EN, match_cnt SHALL be driven constant 0, no counter flops SHALL be inferred, and all other behaviour SHALL be unchanged.

Verification
REQ-029 The bench SHALL cover these directed scenarios (PAT_W=4 unless stated):
- Load 1001, overlap=1, stream 1,0,0,1,0,0,1 with din_valid=1: dout pulses after bit 4 and after bit 7; match_cnt=2.
- Same load and stream with overlap=0: dout pulses after bit 4 only; match_cnt=1.
- Load 1001, stream 1,0 then din_valid=0 for 3 cycles, then 0,1: dout pulses once after the last bit; no pulse during the gap.
- Stream 1,0,0 then pat_load=1 with pattern 0110 and din_valid=1, din=1 on the same edge: din discarded, history cleared, match_cnt=0; a following stream 0,1,1,0 gives one pulse.
- Load 1001, stream 1,0,0, assert reset low asynchronously mid-cycle, release, then send 1: dout stays 0, armed=0, outputs at reset values.
- CNT_W=2 with IIITB_SD_CNT_EN, pattern 11, overlap=1, six consecutive 1s: match_cnt saturates at 3. Without the macro, match_cnt stays 0.
